// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter in front of a DEPTH-entry FIFO.
// Owns the write/read pointers and the occupancy count, and drives
// a one-cycle registered write port into an external storage array.
module fifo_write_arbiter #(
  parameter int NUM_WRITE_PORTS = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 16,
  parameter int ADDR_WIDTH      = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_WRITE_PORTS-1:0]            req,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_WRITE_PORTS-1:0]            gnt,
  output logic                                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0]                 mem_wr_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wr_data,
  output logic [$clog2(NUM_WRITE_PORTS)-1:0]    mem_wr_src,
  input  logic                                  rd_en,
  output logic [ADDR_WIDTH-1:0]                 mem_rd_addr,
  output logic [ADDR_WIDTH:0]                   count,
  output logic                                  full,
  output logic                                  empty,
  output logic                                  underflow_err
);

  localparam int SRC_W = $clog2(NUM_WRITE_PORTS);
  localparam int OCC_W = ADDR_WIDTH + 2;

  // Registered state
  logic [SRC_W-1:0]      prio_q,    prio_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q,  rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,   count_d;
  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [SRC_W-1:0]      wr_src_q,  wr_src_d;
  logic                  uf_q,      uf_d;

  // Arbitration results
  logic [DATA_WIDTH-1:0]      port_data [NUM_WRITE_PORTS];
  logic                       gnt_vld;
  logic [SRC_W-1:0]           gnt_idx;
  logic [SRC_W-1:0]           cand_idx;
  logic [DATA_WIDTH-1:0]      gnt_data;
  logic [NUM_WRITE_PORTS-1:0] gnt_vec;
  int                         cand;

  logic [OCC_W-1:0] occ;
  logic             full_w;
  logic             empty_w;
  logic             pop;

  // Unpack the flat payload bus into one word per requester
  for (genvar g = 0; g < NUM_WRITE_PORTS; g++) begin : g_unpack
    assign port_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // An in-flight write already owns a slot, so it counts towards full
  assign occ     = OCC_W'(count_q) + OCC_W'(wr_en_q);
  assign full_w  = (occ == OCC_W'(DEPTH));
  assign empty_w = (count_q == '0);
  assign pop     = rd_en && !empty_w;

  // Round-robin search starting at the priority pointer; nothing granted in reset or when full
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    gnt_data = '0;
    gnt_vec  = '0;
    cand     = 0;
    if (!rst && !full_w) begin
      for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
        cand = int'(prio_q) + k;
        if (cand >= NUM_WRITE_PORTS) cand = cand - NUM_WRITE_PORTS;
        cand_idx = SRC_W'(cand);
        if (!gnt_vld && req[cand_idx]) begin
          gnt_vld           = 1'b1;
          gnt_idx           = cand_idx;
          gnt_vec[cand_idx] = 1'b1;
          gnt_data          = port_data[cand_idx];
        end
      end
    end
  end

  // Next-state: write pipeline, priority rotation, pointers, occupancy, underflow
  always_comb begin
    prio_d    = prio_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_en_d   = gnt_vld;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    uf_d      = uf_q;

    if (gnt_vld) begin
      wr_addr_d = wr_ptr_q;
      wr_data_d = gnt_data;
      wr_src_d  = gnt_idx;
      wr_ptr_d  = wr_ptr_q + 1'b1;
      prio_d    = (gnt_idx == SRC_W'(NUM_WRITE_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    if (rd_en && empty_w) uf_d = 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // The write registered last cycle commits at this edge
    case ({wr_en_q, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops any in-flight write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
      uf_q      <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
      uf_q      <= uf_d;
    end
  end

  assign gnt           = gnt_vec;
  assign mem_wr_en     = wr_en_q;
  assign mem_wr_addr   = wr_addr_q;
  assign mem_wr_data   = wr_data_q;
  assign mem_wr_src    = wr_src_q;
  assign mem_rd_addr   = rd_ptr_q;
  assign count         = count_q;
  assign full          = full_w;
  assign empty         = empty_w;
  assign underflow_err = uf_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: directed scenarios plus a randomized
// run, all compared against a queue-based model of the FIFO.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic         rd_en = 1'b0;
  logic [N-1:0] gnt;
  logic         mem_wr_en;
  logic [3:0]   mem_wr_addr;
  logic [W-1:0] mem_wr_data;
  logic [1:0]   mem_wr_src;
  logic [3:0]   mem_rd_addr;
  logic [4:0]   count;
  logic         full;
  logic         empty;
  logic         underflow_err;

  fifo_write_arbiter #(.NUM_WRITE_PORTS(N), .DATA_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_src(mem_wr_src), .rd_en(rd_en), .mem_rd_addr(mem_rd_addr),
    .count(count), .full(full), .empty(empty), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // External storage array written by the DUT's write port
  logic [W-1:0] mem [D];
  always @(posedge clk) if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;

  // Reference model state
  int           m_prio, m_wr_ptr, m_rd_ptr, m_gidx, m_wr_addr, m_wr_src;
  bit           m_infl, m_uf, m_full;
  logic [W-1:0] m_wr_data;
  logic [W-1:0] fifo_q [$];
  logic [N-1:0] m_gnt;
  logic [W-1:0] port_data [N];
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic model_reset();
    m_prio = 0; m_wr_ptr = 0; m_rd_ptr = 0; m_infl = 0; m_uf = 0;
    m_wr_addr = 0; m_wr_src = 0; m_wr_data = '0; m_gidx = -1;
    fifo_q.delete();
  endtask

  task automatic model_comb();
    m_full = (fifo_q.size() + int'(m_infl)) == D;
    m_gnt  = '0;
    m_gidx = -1;
    if (!rst && !m_full)
      for (int k = 0; k < N; k++)
        if (m_gidx < 0 && req[(m_prio + k) % N]) m_gidx = (m_prio + k) % N;
    if (m_gidx >= 0) m_gnt[m_gidx] = 1'b1;
  endtask

  task automatic model_seq();
    if (rst) begin model_reset(); return; end
    if (rd_en) begin
      if (fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        m_rd_ptr = (m_rd_ptr + 1) % D;
      end else m_uf = 1;
    end
    if (m_infl) fifo_q.push_back(m_wr_data);
    m_infl = (m_gidx >= 0);
    if (m_gidx >= 0) begin
      m_wr_data = req_data[m_gidx*W +: W];
      m_wr_src  = m_gidx;
      m_wr_addr = m_wr_ptr;
      m_wr_ptr  = (m_wr_ptr + 1) % D;
      m_prio    = (m_gidx + 1) % N;
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic rd);
    req   = r;
    rd_en = rd;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = port_data[i];
    #1;
    model_comb();
  endtask

  task automatic step();
    int g;
    model_comb();
    g = m_gidx;
    model_seq();
    @(posedge clk);
    #1;
    if (g >= 0) port_data[g] = $urandom;
    model_comb();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rd_en = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    model_comb();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; rd_en = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({gnt, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_src, mem_rd_addr, count, full, empty, underflow_err}
        !== {4'b0000, 1'b0, 4'd0, 32'd0, 2'd0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_state: gnt=%b we=%b wa=%0d wd=%h src=%0d ra=%0d cnt=%0d full=%b empty=%b uf=%b expected all zero with empty=1",
               gnt, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_src, mem_rd_addr, count, full, empty, underflow_err);
    else n_pass++;
    rst = 1'b0;
    req = '0;
    #1;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 1'b0);
      n_checks++;
      if (gnt !== (4'b0001 << (c % 4)) || gnt !== m_gnt)
        $display("FAIL rr_gnt cycle %0d: got %b expected %b", c, gnt, 4'b0001 << (c % 4));
      else n_pass++;
      step();
      n_checks++;
      if ({mem_wr_en, mem_wr_src, mem_wr_addr, mem_wr_data} !== {1'b1, 2'(c % 4), 4'(c), m_wr_data})
        $display("FAIL rr_write cycle %0d: got en=%b src=%0d addr=%0d data=%h expected en=1 src=%0d addr=%0d data=%h",
                 c, mem_wr_en, mem_wr_src, mem_wr_addr, mem_wr_data, c % 4, c, m_wr_data);
      else n_pass++;
    end
  endtask

  task automatic test_priority_wrap();
    logic [N-1:0] pats [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0101};
    int           exp_i [5] = '{2, 2, 2, 0, 2};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(pats[c], 1'b0);
      n_checks++;
      if (gnt !== (4'b0001 << exp_i[c]) || gnt !== m_gnt)
        $display("FAIL prio_gnt step %0d: got %b expected %b", c, gnt, 4'b0001 << exp_i[c]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_fill();
    int ng = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(4'b0010, 1'b0);
      n_checks++;
      if (gnt !== m_gnt) $display("FAIL fill_gnt cycle %0d: got %b expected %b", c, gnt, m_gnt);
      else n_pass++;
      if (gnt[1]) ng++;
      step();
    end
    n_checks++;
    if (ng !== 16) $display("FAIL fill_grants: got %0d expected 16", ng); else n_pass++;
    n_checks++;
    if ({count, full} !== {5'd16, 1'b1}) $display("FAIL fill_full: got count=%0d full=%b expected 16/1", count, full);
    else n_pass++;
    drive(4'b0010, 1'b1);
    n_checks++;
    if (gnt !== 4'b0000) $display("FAIL fill_read_same_cycle_gnt: got %b expected 0000", gnt); else n_pass++;
    n_checks++;
    if (mem[mem_rd_addr] !== fifo_q[0]) $display("FAIL fill_head_data: got %h expected %h", mem[mem_rd_addr], fifo_q[0]);
    else n_pass++;
    step();
    drive(4'b0010, 1'b0);
    n_checks++;
    if ({count, full, gnt} !== {5'd15, 1'b0, 4'b0010})
      $display("FAIL fill_after_pop: got count=%0d full=%b gnt=%b expected 15/0/0010", count, full, gnt);
    else n_pass++;
    step();
    n_checks++;
    if ({mem_wr_en, mem_wr_addr} !== {1'b1, 4'd0})
      $display("FAIL fill_wrap_write: got en=%b addr=%0d expected 1/0", mem_wr_en, mem_wr_addr);
    else n_pass++;
  endtask

  task automatic test_underflow();
    do_reset();
    drive(4'b0000, 1'b1);
    n_checks++;
    if ({empty, gnt} !== {1'b1, 4'b0000}) $display("FAIL uf_pre: got empty=%b gnt=%b expected 1/0000", empty, gnt);
    else n_pass++;
    step();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0000, 1'b0);
      n_checks++;
      if ({underflow_err, mem_rd_addr, count} !== {1'b1, 4'd0, 5'd0} || underflow_err !== m_uf)
        $display("FAIL uf_sticky cycle %0d: got uf=%b ra=%0d cnt=%0d expected 1/0/0", c, underflow_err, mem_rd_addr, count);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_stream();
    int grants = 0, wraps_w = 0, wraps_r = 0, prev_wa = 0, prev_ra = 0, maxcnt = 0;
    logic rd;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      rd = (fifo_q.size() > 0);
      drive(grants < 40 ? 4'b1000 : 4'b0000, rd);
      n_checks++;
      if ({gnt, count, mem_rd_addr} !== {m_gnt, 5'(fifo_q.size()), 4'(m_rd_ptr)})
        $display("FAIL stream_state cycle %0d: got gnt=%b cnt=%0d ra=%0d expected %b/%0d/%0d",
                 c, gnt, count, mem_rd_addr, m_gnt, fifo_q.size(), m_rd_ptr);
      else n_pass++;
      if (rd) begin
        n_checks++;
        if (mem[mem_rd_addr] !== fifo_q[0])
          $display("FAIL stream_data cycle %0d: got %h expected %h", c, mem[mem_rd_addr], fifo_q[0]);
        else n_pass++;
      end
      if (int'(count) > maxcnt) maxcnt = int'(count);
      if (gnt[3]) grants++;
      step();
      n_checks++;
      if (mem_wr_en !== m_infl || (m_infl && mem_wr_addr !== 4'(m_wr_addr)))
        $display("FAIL stream_write cycle %0d: got en=%b addr=%0d expected %b/%0d", c, mem_wr_en, mem_wr_addr, m_infl, m_wr_addr);
      else n_pass++;
      if (mem_wr_en) begin
        if (prev_wa == 15 && mem_wr_addr == 4'd0) wraps_w++;
        prev_wa = int'(mem_wr_addr);
      end
      if (prev_ra == 15 && mem_rd_addr == 4'd0) wraps_r++;
      prev_ra = int'(mem_rd_addr);
    end
    n_checks++;
    if (grants != 40 || wraps_w != 2 || wraps_r != 2)
      $display("FAIL stream_totals: got grants=%0d wr_wraps=%0d rd_wraps=%0d expected 40/2/2", grants, wraps_w, wraps_r);
    else n_pass++;
    n_checks++;
    if (maxcnt > 2 || count !== 5'd0) $display("FAIL stream_count: got max=%0d final=%0d expected <=2/0", maxcnt, count);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    drive(4'b1100, 1'b0);
    n_checks++;
    if (gnt !== 4'b0100) $display("FAIL midrst_first_gnt: got %b expected 0100", gnt); else n_pass++;
    step();
    n_checks++;
    if (mem_wr_en !== 1'b1) $display("FAIL midrst_inflight: got %b expected 1", mem_wr_en); else n_pass++;
    #1;
    rst = 1'b1;
    req = 4'b1111;
    #1;
    model_reset();
    n_checks++;
    if ({mem_wr_en, count, mem_wr_addr, mem_rd_addr, mem_wr_src, gnt} !== '0)
      $display("FAIL midrst_clear: got en=%b cnt=%0d wa=%0d ra=%0d src=%0d gnt=%b expected all zero",
               mem_wr_en, count, mem_wr_addr, mem_rd_addr, mem_wr_src, gnt);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'b1111, 1'b0);
    n_checks++;
    if (gnt !== 4'b0001 || gnt !== m_gnt) $display("FAIL midrst_regnt: got %b expected 0001", gnt); else n_pass++;
    step();
    n_checks++;
    if ({mem_wr_en, mem_wr_addr, mem_wr_src, count} !== {1'b1, 4'd0, 2'd0, 5'd0})
      $display("FAIL midrst_write: got en=%b wa=%0d src=%0d cnt=%0d expected 1/0/0/0", mem_wr_en, mem_wr_addr, mem_wr_src, count);
    else n_pass++;
    drive(4'b0000, 1'b0);
    step();
    n_checks++;
    if (count !== 5'd1) $display("FAIL midrst_count: got %0d expected 1", count); else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] reqs = '0;
    logic         rd;
    int           g;
    int           pct;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pct = (c < 200) ? 25 : 70;
      for (int i = 0; i < N; i++) if (!reqs[i] && $urandom_range(0, 1) == 1) reqs[i] = 1'b1;
      rd = ($urandom_range(0, 99) < pct);
      drive(reqs, rd);
      n_checks++;
      if ({gnt, full, empty, count, mem_rd_addr, underflow_err}
          !== {m_gnt, m_full, fifo_q.size() == 0, 5'(fifo_q.size()), 4'(m_rd_ptr), m_uf})
        $display("FAIL rand_state cycle %0d: got gnt=%b full=%b empty=%b cnt=%0d ra=%0d uf=%b expected %b/%b/%b/%0d/%0d/%b",
                 c, gnt, full, empty, count, mem_rd_addr, underflow_err,
                 m_gnt, m_full, fifo_q.size() == 0, fifo_q.size(), m_rd_ptr, m_uf);
      else n_pass++;
      if (rd && fifo_q.size() > 0) begin
        n_checks++;
        if (mem[mem_rd_addr] !== fifo_q[0])
          $display("FAIL rand_data cycle %0d: got %h expected %h", c, mem[mem_rd_addr], fifo_q[0]);
        else n_pass++;
      end
      g = m_gidx;
      step();
      if (g >= 0) reqs[g] = 1'b0;
      n_checks++;
      if (mem_wr_en !== m_infl ||
          (m_infl && {mem_wr_addr, mem_wr_data, mem_wr_src} !== {4'(m_wr_addr), m_wr_data, 2'(m_wr_src)}))
        $display("FAIL rand_write cycle %0d: got en=%b wa=%0d wd=%h src=%0d expected %b/%0d/%h/%0d",
                 c, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_src, m_infl, m_wr_addr, m_wr_data, m_wr_src);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) port_data[i] = $urandom;
    test_reset();
    test_round_robin();
    test_priority_wrap();
    test_fill();
    test_underflow();
    test_stream();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares one FIFO write path between NUM_WRITE_PORTS requesters using round-robin arbitration.
- Owns the FIFO read/write pointers and occupancy, and drives address, data and enable to an external DEPTH-entry storage array.
- Read consumers pop through rd_en.
- Commits writes strictly in grant order, so the FIFO data-order checker can track sequence per source via mem_wr_src.

Parameters:
- NUM_WRITE_PORTS, 4, number of requesters (>=2).
- DATA_WIDTH, 32, payload width.
- DEPTH, 16, FIFO entries; power of two, >=2.
- ADDR_WIDTH, $clog2(DEPTH), derived; not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  NUM_WRITE_PORTS  per-requester write request; must hold with data stable until granted.
- req_data  input  NUM_WRITE_PORTS*DATA_WIDTH  packed payloads; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_WRITE_PORTS  one-hot-or-zero grant, combinational; a transfer occurs when req[i] & gnt[i].
- mem_wr_en  output  1  registered storage write strobe.
- mem_wr_addr  output  ADDR_WIDTH  registered write address.
- mem_wr_data  output  DATA_WIDTH  registered write payload.
- mem_wr_src  output  $clog2(NUM_WRITE_PORTS)  index of the requester whose data is being written.
- rd_en  input  1  pop request from consumer.
- mem_rd_addr  output  ADDR_WIDTH  current read pointer (head entry).
- count  output  ADDR_WIDTH+1  committed entries, 0..DEPTH.
- full  output  1  no grant possible.
- empty  output  1  count==0.
- underflow_err  output  1  sticky; set by rd_en while empty.

Behaviour:
- Reset, asynchronous: gnt=0 (no requests can be granted while rst is high); mem_wr_en=0; mem_wr_addr=0; mem_wr_data=0; mem_wr_src=0; mem_rd_addr=0; count=0; full=0; empty=1; underflow_err=0.
- Internal state also resets: write pointer=0, in-flight flag=0, round-robin priority pointer=0.
- Arbitration:
  - Search starts at the priority pointer p and runs p, p+1, ..., wrapping modulo NUM_WRITE_PORTS.
  - The first index with req set is granted, provided full=0.
  - At most one grant per cycle. Grants are 0 when full=1 or when no req is set.
- Priority update: after a grant to index i, p becomes (i+1) mod NUM_WRITE_PORTS at the next edge. Otherwise p holds.
- Write pipeline, latency 1:
  - A grant in cycle t registers mem_wr_en=1 in cycle t+1, with mem_wr_addr=wr_ptr, mem_wr_data=req_data[i] and mem_wr_src=i.
  - wr_ptr increments, wrapping DEPTH-1 to 0.
  - The in-flight flag is set for cycle t+1.
- Commit: count increments at the end of the mem_wr_en cycle. An entry is therefore visible (empty deasserts) in cycle t+2.
- full = (count + in-flight) == DEPTH, computed combinationally from registered state. A read in the same cycle does not free a slot for a grant in that cycle.
- Read:
  - rd_en with empty=0 increments mem_rd_addr (wrapping) and decrements count at the edge.
  - rd_en with empty=1 does nothing to the pointers and sets underflow_err. It clears only on rst.
- Simultaneous commit and pop: count unchanged; both pointers advance.
- Ordering: storage order equals grant order. Per source, data is stored in request order.
- Reset mid-operation:
  - An in-flight write is dropped: mem_wr_en deasserts immediately.
  - The grant for that cycle is discarded.
  - All pointers return to 0.
- Back-to-back: one grant per cycle is sustained while not full.

Test Plan:
1. After reset, req=4'b1111, FIFO empty -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles. mem_wr_src reads 0,1,2,3,0, each one cycle after its grant. mem_wr_addr reads 0,1,2,3,4.
2. Only req[2] held for 3 cycles, then req=4'b0101 -> first three grants go to 2. The next grant goes to 0 (p=3 wraps to 0), then 2.
3. Fill: req[1] held continuously with DEPTH=16 -> exactly 16 grants. gnt stays 0 once count+in-flight=16; full=1 and count=16 two cycles after the 16th grant. Assert rd_en for one cycle -> count=15, full=0, and the next grant follows in the cycle after.
4. Pop when empty: rd_en=1 right after reset -> underflow_err=1 and stays 1, mem_rd_addr=0, count=0.
5. Steady stream: 40 writes from req[3] with rd_en asserted once per write -> mem_wr_addr and mem_rd_addr wrap 15->0 twice. Data read at each mem_rd_addr matches write order; count never exceeds 2.
6. Assert rst in the cycle after a grant, with mem_wr_en high -> mem_wr_en, count, pointers and gnt are 0 immediately. After release, the first grant goes to the lowest-index requester and writes address 0.
